// File: rtl/sirv_qspi_link_arbiter_if.sv
// Bundle of every requester-side and media-side signal around the QSPI link
// arbiter. The slave modport is the arbiter's view; the master modport is the
// surrounding environment (both front ends plus sirv_qspi_media).
interface sirv_qspi_link_arbiter_if;
  // Requester 0
  logic       io_inner_0_tx_valid;
  logic       io_inner_0_tx_ready;
  logic [7:0] io_inner_0_tx_bits;
  logic       io_inner_0_rx_valid;
  logic [7:0] io_inner_0_rx_bits;
  logic [7:0] io_inner_0_cnt;
  logic [3:0] io_inner_0_fmt;
  logic [2:0] io_inner_0_cs;
  logic       io_inner_0_active;
  // Requester 1
  logic       io_inner_1_tx_valid;
  logic       io_inner_1_tx_ready;
  logic [7:0] io_inner_1_tx_bits;
  logic       io_inner_1_rx_valid;
  logic [7:0] io_inner_1_rx_bits;
  logic [7:0] io_inner_1_cnt;
  logic [3:0] io_inner_1_fmt;
  logic [2:0] io_inner_1_cs;
  logic       io_inner_1_active;
  // Shared media link
  logic       io_outer_tx_valid;
  logic       io_outer_tx_ready;
  logic [7:0] io_outer_tx_bits;
  logic       io_outer_rx_valid;
  logic [7:0] io_outer_rx_bits;
  logic [7:0] io_outer_cnt;
  logic [3:0] io_outer_fmt;
  logic [2:0] io_outer_cs;
  logic       io_outer_active;
  // Debug
  logic       io_owner;

  modport slave (
    input  io_inner_0_tx_valid, io_inner_0_tx_bits, io_inner_0_cnt,
           io_inner_0_fmt, io_inner_0_cs,
    output io_inner_0_tx_ready, io_inner_0_rx_valid, io_inner_0_rx_bits,
           io_inner_0_active,
    input  io_inner_1_tx_valid, io_inner_1_tx_bits, io_inner_1_cnt,
           io_inner_1_fmt, io_inner_1_cs,
    output io_inner_1_tx_ready, io_inner_1_rx_valid, io_inner_1_rx_bits,
           io_inner_1_active,
    output io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt,
           io_outer_cs,
    input  io_outer_tx_ready, io_outer_rx_valid, io_outer_rx_bits,
           io_outer_active,
    output io_owner
  );

  modport master (
    output io_inner_0_tx_valid, io_inner_0_tx_bits, io_inner_0_cnt,
           io_inner_0_fmt, io_inner_0_cs,
    input  io_inner_0_tx_ready, io_inner_0_rx_valid, io_inner_0_rx_bits,
           io_inner_0_active,
    output io_inner_1_tx_valid, io_inner_1_tx_bits, io_inner_1_cnt,
           io_inner_1_fmt, io_inner_1_cs,
    input  io_inner_1_tx_ready, io_inner_1_rx_valid, io_inner_1_rx_bits,
           io_inner_1_active,
    input  io_outer_tx_valid, io_outer_tx_bits, io_outer_cnt, io_outer_fmt,
           io_outer_cs,
    output io_outer_tx_ready, io_outer_rx_valid, io_outer_rx_bits,
           io_outer_active,
    input  io_owner
  );
endinterface

// File: rtl/sirv_qspi_link_arbiter.sv
// Two-requester arbiter sharing one QSPI media link. A requester owns the
// link for a whole chip-select transaction: the grant is held until the media
// drops io_outer_active, so frames from the two sides never interleave.
// Optional build macro SIRV_QSPI_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; without it requester 0 always wins a tie.
module sirv_qspi_link_arbiter (
  input  logic                            clock,
  input  logic                            reset,
  sirv_qspi_link_arbiter_if.slave         link
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       rxLate_q, rxLate_d;

  logic [1:0] txValid;
  logic [7:0] txBits [2];
  logic [7:0] cnt    [2];
  logic [3:0] fmt    [2];
  logic [2:0] cs     [2];
  logic       winner;
  logic       owning;
  logic       rxSteer;

  assign txValid   = {link.io_inner_1_tx_valid, link.io_inner_0_tx_valid};
  assign txBits[0] = link.io_inner_0_tx_bits;
  assign txBits[1] = link.io_inner_1_tx_bits;
  assign cnt[0]    = link.io_inner_0_cnt;
  assign cnt[1]    = link.io_inner_1_cnt;
  assign fmt[0]    = link.io_inner_0_fmt;
  assign fmt[1]    = link.io_inner_1_fmt;
  assign cs[0]     = link.io_inner_0_cs;
  assign cs[1]     = link.io_inner_1_cs;

`ifdef SIRV_QSPI_ARB_RR_EN
  logic rrPtr_q, rrPtr_d;

  // Tie goes to the round-robin pointer; a lone requester always wins.
  always_comb begin
    winner = ~txValid[0];
    if (&txValid) begin
      winner = rrPtr_q;
    end
  end

  // Pointer flips to the other side each time a grant is issued from IDLE.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if ((state_q == IDLE) && (|txValid)) begin
      rrPtr_d = ~winner;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is not asking.
  assign winner = ~txValid[0];
`endif

  // Arbiter state, owner and late-RX flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      rxLate_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rxLate_q <= rxLate_d;
    end
  end

  // Next-state: grant from IDLE only, release when the media goes inactive.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rxLate_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|txValid) begin
          sel_d   = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (link.io_outer_active) begin
          state_d = LOCKED;
        end else if (!txValid[sel_q]) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (!link.io_outer_active) begin
          state_d  = IDLE;
          rxLate_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Forward the owner to the media and steer handshakes back to it alone.
  always_comb begin
    owning  = (state_q != IDLE);
    rxSteer = (owning | rxLate_q) & link.io_outer_rx_valid;

    link.io_outer_tx_valid   = owning & txValid[sel_q];
    link.io_outer_tx_bits    = owning ? txBits[sel_q] : 8'h00;
    link.io_outer_cnt        = cnt[sel_q];
    link.io_outer_fmt        = fmt[sel_q];
    link.io_outer_cs         = cs[sel_q];

    link.io_inner_0_tx_ready = owning & ~sel_q & link.io_outer_tx_ready;
    link.io_inner_1_tx_ready = owning &  sel_q & link.io_outer_tx_ready;
    link.io_inner_0_rx_valid = rxSteer & ~sel_q;
    link.io_inner_1_rx_valid = rxSteer &  sel_q;
    link.io_inner_0_rx_bits  = link.io_outer_rx_bits;
    link.io_inner_1_rx_bits  = link.io_outer_rx_bits;
    link.io_inner_0_active   = link.io_outer_active & owning & ~sel_q;
    link.io_inner_1_active   = link.io_outer_active & owning &  sel_q;

    link.io_owner            = sel_q;
  end

endmodule

// File: tb/tb_sirv_qspi_link_arbiter.sv
// Testbench for sirv_qspi_link_arbiter. Build with SIRV_QSPI_ARB_RR_EN defined
// to exercise the round-robin variant; expected grant order follows the macro.
module tb_sirv_qspi_link_arbiter;

  localparam logic [7:0] C0_CNT = 8'h08;
  localparam logic [3:0] C0_FMT = 4'h1;
  localparam logic [2:0] C0_CS  = 3'b001;
  localparam logic [7:0] C1_CNT = 8'h20;
  localparam logic [3:0] C1_FMT = 4'hA;
  localparam logic [2:0] C1_CS  = 3'b101;

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic [7:0] b0;
    logic       v1;
    logic [7:0] b1;
    logic       rdy;
    logic       act;
    logic       rxv;
    logic [7:0] rxb;
    logic       eOV;
    logic [7:0] eOB;
    logic       eR0;
    logic       eR1;
    logic       eRx0;
    logic       eRx1;
    logic       eA0;
    logic       eA1;
    logic       eOwn;
    logic       eMux;
  } vec_t;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } sbEntry_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   sbOn   = 1'b0;
  sbEntry_t sbQ[$];
  vec_t vecs[20];

  always #5 clock = ~clock;

  sirv_qspi_link_arbiter_if link();

  sirv_qspi_link_arbiter dut (
    .clock (clock),
    .reset (reset),
    .link  (link)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %0h expected %0h", name, idx, actual, expected);
    end
  endtask

  task automatic driveIdle();
    link.io_inner_0_tx_valid = 1'b0;
    link.io_inner_0_tx_bits  = 8'h00;
    link.io_inner_1_tx_valid = 1'b0;
    link.io_inner_1_tx_bits  = 8'h00;
    link.io_outer_tx_ready   = 1'b0;
    link.io_outer_active     = 1'b0;
    link.io_outer_rx_valid   = 1'b0;
    link.io_outer_rx_bits    = 8'h00;
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset = 1'b1;
    driveIdle();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Pops the expected byte/owner whenever the media accepts a byte.
  task automatic scoreboardMonitor(input int idx);
    sbEntry_t exp;
    if (sbOn && link.io_outer_tx_valid && link.io_outer_tx_ready) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected (step %0d): got byte %0h expected none",
                 idx, link.io_outer_tx_bits);
      end else begin
        exp = sbQ.pop_front();
        check("sb_owner", idx, {31'd0, link.io_owner}, {31'd0, exp.owner});
        check("sb_byte", idx, {24'd0, link.io_outer_tx_bits}, {24'd0, exp.data});
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset                    = v.rst;
    link.io_inner_0_tx_valid = v.v0;
    link.io_inner_0_tx_bits  = v.b0;
    link.io_inner_1_tx_valid = v.v1;
    link.io_inner_1_tx_bits  = v.b1;
    link.io_outer_tx_ready   = v.rdy;
    link.io_outer_active     = v.act;
    link.io_outer_rx_valid   = v.rxv;
    link.io_outer_rx_bits    = v.rxb;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [14:0] expFields;
    #1;
    expFields = v.eMux ? {C1_CNT, C1_FMT, C1_CS} : {C0_CNT, C0_FMT, C0_CS};
    check("outer_tx_valid", idx, {31'd0, link.io_outer_tx_valid}, {31'd0, v.eOV});
    check("outer_tx_bits", idx, {24'd0, link.io_outer_tx_bits}, {24'd0, v.eOB});
    check("tx_ready0", idx, {31'd0, link.io_inner_0_tx_ready}, {31'd0, v.eR0});
    check("tx_ready1", idx, {31'd0, link.io_inner_1_tx_ready}, {31'd0, v.eR1});
    check("rx_valid0", idx, {31'd0, link.io_inner_0_rx_valid}, {31'd0, v.eRx0});
    check("rx_valid1", idx, {31'd0, link.io_inner_1_rx_valid}, {31'd0, v.eRx1});
    check("active0", idx, {31'd0, link.io_inner_0_active}, {31'd0, v.eA0});
    check("active1", idx, {31'd0, link.io_inner_1_active}, {31'd0, v.eA1});
    check("owner", idx, {31'd0, link.io_owner}, {31'd0, v.eOwn});
    check("cnt_fmt_cs", idx, {17'd0, link.io_outer_cnt, link.io_outer_fmt, link.io_outer_cs},
          {17'd0, expFields});
    check("rx_bits0", idx, {24'd0, link.io_inner_0_rx_bits}, {24'd0, v.rxb});
    check("rx_bits1", idx, {24'd0, link.io_inner_1_rx_bits}, {24'd0, v.rxb});
  endtask

  // Requester 0 streams three bytes through one chip-select frame.
  task automatic runFrameSeq();
    logic [7:0] bytes [3];
    int  idx    = 0;
    int  after  = 0;
    bit  pushed = 1'b0;
    bit  r1Seen = 1'b0;
    bit  actM   = 1'b0;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h5A;
    bytes[2] = 8'h3C;
    sbOn = 1'b1;
    for (int cyc = 0; cyc < 40 && !(idx == 3 && after >= 3); cyc++) begin
      @(negedge clock);
      link.io_inner_0_tx_valid = (idx < 3);
      link.io_inner_0_tx_bits  = (idx < 3) ? bytes[idx] : 8'h00;
      link.io_inner_1_tx_valid = 1'b0;
      link.io_outer_tx_ready   = 1'b1;
      link.io_outer_active     = actM;
      if (idx < 3 && !pushed) begin
        sbQ.push_back({1'b0, bytes[idx]});
        pushed = 1'b1;
      end
      #1;
      scoreboardMonitor(1000 + cyc);
      if (link.io_inner_1_tx_ready) r1Seen = 1'b1;
      if (idx < 3 && link.io_inner_0_tx_ready) begin
        idx++;
        pushed = 1'b0;
        actM   = 1'b1;
      end else if (idx == 3) begin
        after++;
        if (after == 2) actM = 1'b0;
      end
    end
    check("frame_bytes_sent", 1100, idx, 3);
    check("frame_sb_empty", 1101, sbQ.size(), 0);
    check("frame_ready1_quiet", 1102, {31'd0, r1Seen}, 32'd0);
    sbOn = 1'b0;
    driveIdle();
  endtask

  // Both requesters ask continuously; the media takes one byte per frame.
  task automatic runContendSeq();
    int mediaCnt = 0;
    int hsCount  = 0;
`ifdef SIRV_QSPI_ARB_RR_EN
    sbQ.push_back({1'b0, 8'hB0});
    sbQ.push_back({1'b1, 8'hB1});
    sbQ.push_back({1'b0, 8'hB0});
`else
    sbQ.push_back({1'b0, 8'hB0});
    sbQ.push_back({1'b0, 8'hB0});
    sbQ.push_back({1'b0, 8'hB0});
`endif
    sbOn = 1'b1;
    for (int cyc = 0; cyc < 60 && hsCount < 3; cyc++) begin
      @(negedge clock);
      link.io_inner_0_tx_valid = 1'b1;
      link.io_inner_0_tx_bits  = 8'hB0;
      link.io_inner_1_tx_valid = 1'b1;
      link.io_inner_1_tx_bits  = 8'hB1;
      link.io_outer_active     = (mediaCnt >= 3);
      link.io_outer_tx_ready   = (mediaCnt == 0);
      #1;
      scoreboardMonitor(2000 + cyc);
      if (link.io_outer_tx_valid && link.io_outer_tx_ready) begin
        hsCount++;
        mediaCnt = 4;
      end else if (mediaCnt > 0) begin
        mediaCnt--;
      end
    end
    check("contend_grants", 2100, hsCount, 3);
    check("contend_sb_empty", 2101, sbQ.size(), 0);
    sbOn = 1'b0;
    driveIdle();
  endtask

  initial begin
    link.io_inner_0_cnt = C0_CNT;
    link.io_inner_0_fmt = C0_FMT;
    link.io_inner_0_cs  = C0_CS;
    link.io_inner_1_cnt = C1_CNT;
    link.io_inner_1_fmt = C1_FMT;
    link.io_inner_1_cs  = C1_CS;
    driveIdle();

    //         rst  v0   b0     v1   b1     rdy  act  rxv  rxb    | eOV eOB   eR0  eR1  eRx0 eRx1 eA0  eA1  eOwn eMux
    vecs[0]  = {1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = {1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = {1'b0,1'b0,8'h00,1'b1,8'h77,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = {1'b0,1'b0,8'h00,1'b1,8'h77,1'b0,1'b0,1'b0,8'h00, 1'b1,8'h77,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vecs[4]  = {1'b0,1'b0,8'h00,1'b0,8'h77,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h77,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vecs[5]  = {1'b0,1'b0,8'h00,1'b0,8'h77,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vecs[6]  = {1'b0,1'b0,8'h00,1'b1,8'h11,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    vecs[7]  = {1'b0,1'b0,8'h00,1'b1,8'h11,1'b0,1'b1,1'b1,8'h96, 1'b1,8'h11,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
    vecs[8]  = {1'b0,1'b1,8'h33,1'b1,8'h22,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h22,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[9]  = {1'b0,1'b1,8'h33,1'b0,8'h22,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h22,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[10] = {1'b0,1'b1,8'h33,1'b0,8'h22,1'b1,1'b0,1'b1,8'h5C, 1'b0,8'h22,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1};
    vecs[11] = {1'b0,1'b1,8'h33,1'b0,8'h22,1'b1,1'b0,1'b1,8'h5D, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1};
    vecs[12] = {1'b0,1'b1,8'h33,1'b0,8'h22,1'b1,1'b0,1'b1,8'h5E, 1'b1,8'h33,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[13] = {1'b0,1'b0,8'h33,1'b0,8'h22,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h33,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[14] = {1'b0,1'b0,8'h33,1'b0,8'h22,1'b0,1'b0,1'b1,8'h44, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[15] = {1'b0,1'b0,8'h00,1'b1,8'h55,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[16] = {1'b0,1'b0,8'h00,1'b1,8'h55,1'b0,1'b1,1'b0,8'h00, 1'b1,8'h55,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[17] = {1'b1,1'b0,8'h00,1'b1,8'h55,1'b1,1'b1,1'b0,8'h00, 1'b1,8'h55,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
    vecs[18] = {1'b0,1'b0,8'h00,1'b1,8'h55,1'b1,1'b1,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[19] = {1'b0,1'b0,8'h00,1'b0,8'h55,1'b0,1'b0,1'b0,8'h00, 1'b0,8'h55,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};

    resetDut();
    $display("[TB] table vectors");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    @(negedge clock);
    driveIdle();
    reset = 1'b0;

    $display("[TB] three-byte frame from requester 0");
    resetDut();
    runFrameSeq();

    $display("[TB] simultaneous requests");
    resetDut();
    runContendSeq();

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
